// File: rtl/gol_pkg.sv
// Shared types and helpers for the Game-of-Life run controller.
// Holds the datapath select encoding, the FSM state and halt-reason
// enumerations, the grid width, and the state-to-output decode helpers.
package gol_pkg;

    localparam int GRID_W = 64;

    // Source select driven onto the datapath `a` input.
    typedef enum logic [1:0] {
        SEL_LOAD   = 2'b00,   // user Grid into the register
        SEL_EVOLVE = 2'b01,   // next generation into the register
        SEL_HOLD   = 2'b10,   // register keeps its value
        SEL_RANDOM = 2'b11    // LFSR into the register
    } sel_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEED   = 3'd1,
        RUN    = 3'd2,
        EVOLVE = 3'd3,
        CHECK  = 3'd4,
        PAUSED = 3'd5,
        HALT   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        NONE    = 2'b00,
        EXTINCT = 2'b01,
        STABLE  = 2'b10,
        LIMIT   = 2'b11
    } reason_t;

    // Datapath select for a given state; in SEED the source follows the
    // seed_random value captured together with start.
    function automatic sel_t sel_for(input state_t s, input logic rnd);
        sel_t r;
        case (s)
            IDLE:    r = SEL_LOAD;
            SEED: begin
                if (rnd) begin
                    r = SEL_RANDOM;
                end else begin
                    r = SEL_LOAD;
                end
            end
            RUN:     r = SEL_HOLD;
            EVOLVE:  r = SEL_EVOLVE;
            CHECK:   r = SEL_HOLD;
            PAUSED:  r = SEL_HOLD;
            HALT:    r = SEL_HOLD;
            default: r = SEL_LOAD;
        endcase
        return r;
    endfunction

    // busy covers every state where the controller is actively sequencing.
    function automatic logic is_busy(input state_t s);
        logic r;
        case (s)
            SEED, RUN, EVOLVE, CHECK: r = 1'b1;
            default:                  r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gol_tick_div.sv
// Pacing counter for the RUN state: counts enabled cycles and raises a
// one-cycle tick on the TICK_DIV-th one, then wraps to zero. clr forces
// the count back to zero so every RUN stretch starts with a full wait.
// The tick is decoded from the count so the FSM can leave RUN on the
// exact cycle the wait expires.
module gol_tick_div
    import gol_pkg::*;
#(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise advance and wrap while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = CNT_ZERO;
        end else if (en) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = CNT_ZERO;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && !clr && (cnt_q == CNT_LAST);

endmodule

// File: rtl/gol_run_ctrl.sv
// Run-control FSM for the 8x8 Game-of-Life datapath. Sequences seeding,
// paced evolution, pause/step/stop, and halts on extinction, still life
// or a generation limit. All outputs are registered and decoded from the
// next state so they line up with the state they describe.
// Optional build macro GOL_OSC2_DETECT_EN: keeps the grid from two
// generations back so period-2 oscillators also halt as STABLE.
module gol_run_ctrl
    import gol_pkg::*;
#(
    parameter int GEN_W    = 16,
    parameter int TICK_DIV = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              step,
    input  logic              seed_random,
    input  logic [GEN_W-1:0]  gen_limit,
    input  logic [GRID_W-1:0] grid_state,
    output logic [1:0]        sel,
    output logic              busy,
    output logic              done,
    output logic [1:0]        reason,
    output logic [GEN_W-1:0]  gen_count
);

    localparam logic [GEN_W-1:0]  GEN_ZERO  = {GEN_W{1'b0}};
    localparam logic [GEN_W-1:0]  GEN_ONE   = GEN_W'(1);
    localparam logic [GEN_W-1:0]  GEN_MAX   = {GEN_W{1'b1}};
    localparam logic [GRID_W-1:0] GRID_ZERO = {GRID_W{1'b0}};

    state_t            state_q,     state_d;
    sel_t              sel_q,       sel_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;
    reason_t           reason_q,    reason_d;
    logic [GEN_W-1:0]  gen_count_q, gen_count_d;
    logic [GRID_W-1:0] prev_grid_q, prev_grid_d;
    logic              from_step_q, from_step_d;
`ifdef GOL_OSC2_DETECT_EN
    logic [GRID_W-1:0] prev2_grid_q, prev2_grid_d;
`endif

    logic tick;
    logic stable_s;
    logic limit_hit_s;

    // Pacing counter only runs in RUN and is held clear everywhere else,
    // so each entry into RUN waits a full TICK_DIV cycles.
    gol_tick_div #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_div (
        .clk   (clk),
        .reset (reset),
        .clr   (state_q != RUN),
        .en    (state_q == RUN),
        .tick  (tick)
    );

    // Halt conditions evaluated in CHECK against the freshly evolved grid.
    always_comb begin
`ifdef GOL_OSC2_DETECT_EN
        stable_s = (grid_state == prev_grid_q) ||
                   ((grid_state == prev2_grid_q) && (gen_count_q >= GEN_W'(2)));
`else
        stable_s = (grid_state == prev_grid_q);
`endif
        limit_hit_s = (gen_limit != GEN_ZERO) && (gen_count_q == gen_limit);
    end

    // Next-state, bookkeeping and registered-output decode.
    always_comb begin
        state_d     = state_q;
        reason_d    = reason_q;
        gen_count_d = gen_count_q;
        prev_grid_d = prev_grid_q;
        from_step_d = from_step_q;
`ifdef GOL_OSC2_DETECT_EN
        prev2_grid_d = prev2_grid_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = SEED;
                    gen_count_d = GEN_ZERO;
                    reason_d    = NONE;
                end else begin
                    state_d = IDLE;
                end
            end
            SEED: begin
                state_d = RUN;
            end
            RUN: begin
                // stop beats a tick landing in the same cycle
                if (stop) begin
                    state_d = PAUSED;
                end else if (tick) begin
                    state_d     = EVOLVE;
                    from_step_d = 1'b0;
                end else begin
                    state_d = RUN;
                end
            end
            EVOLVE: begin
                // grid_state still holds the pre-evolution generation here
                prev_grid_d = grid_state;
`ifdef GOL_OSC2_DETECT_EN
                prev2_grid_d = prev_grid_q;
`endif
                if (gen_count_q != GEN_MAX) begin
                    gen_count_d = gen_count_q + GEN_ONE;
                end else begin
                    gen_count_d = gen_count_q;
                end
                state_d = CHECK;
            end
            CHECK: begin
                if (grid_state == GRID_ZERO) begin
                    state_d  = HALT;
                    reason_d = EXTINCT;
                end else if (stable_s) begin
                    state_d  = HALT;
                    reason_d = STABLE;
                end else if (limit_hit_s) begin
                    state_d  = HALT;
                    reason_d = LIMIT;
                end else if (from_step_q) begin
                    state_d = PAUSED;
                end else begin
                    state_d = RUN;
                end
            end
            PAUSED: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (start) begin
                    state_d = RUN;
                end else if (step) begin
                    state_d     = EVOLVE;
                    from_step_d = 1'b1;
                end else begin
                    state_d = PAUSED;
                end
            end
            HALT: begin
                if (start) begin
                    state_d     = SEED;
                    gen_count_d = GEN_ZERO;
                    reason_d    = NONE;
                end else begin
                    state_d = HALT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        sel_d  = sel_for(state_d, seed_random);
        busy_d = is_busy(state_d);
        done_d = (state_d == HALT);
    end

    // FSM state, bookkeeping and output registers with synchronous reset;
    // reset abandons any in-flight evolution.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sel_q       <= SEL_LOAD;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            reason_q    <= NONE;
            gen_count_q <= GEN_ZERO;
            prev_grid_q <= GRID_ZERO;
            from_step_q <= 1'b0;
`ifdef GOL_OSC2_DETECT_EN
            prev2_grid_q <= GRID_ZERO;
`endif
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            reason_q    <= reason_d;
            gen_count_q <= gen_count_d;
            prev_grid_q <= prev_grid_d;
            from_step_q <= from_step_d;
`ifdef GOL_OSC2_DETECT_EN
            prev2_grid_q <= prev2_grid_d;
`endif
        end
    end

    assign sel       = sel_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign reason    = reason_q;
    assign gen_count = gen_count_q;

endmodule

// File: tb/tb_gol_run_ctrl.sv
// Testbench for gol_run_ctrl. Contains a behavioural 8x8 Life datapath
// (register + LFSR, driven by sel) closed around the controller, and a
// generation-level reference model that predicts halt reason, generation
// count, final grid and halt latency from the Life rules.
module tb_gol_run_ctrl;

    localparam int GEN_W    = 16;
    localparam int TICK_DIV = 4;
    localparam int PERIOD   = TICK_DIV + 2;

    localparam logic [63:0] G_SINGLE  = 64'h0000_0000_0008_0000;
    localparam logic [63:0] G_BLOCK   = 64'h0000_0000_1818_0000;
    localparam logic [63:0] G_BLINKER = 64'h0000_0000_0038_0000;
    localparam logic [63:0] G_GLIDER  = 64'h0000_0000_0E08_0400;
`ifdef GOL_OSC2_DETECT_EN
    localparam logic [63:0] G_PAUSE   = G_GLIDER;
`else
    localparam logic [63:0] G_PAUSE   = G_BLINKER;
`endif

    logic              clk = 1'b0;
    logic              reset, start, stop, step, seed_random;
    logic [GEN_W-1:0]  gen_limit;
    logic [63:0]       user_grid;
    logic [63:0]       dp_q, lfsr_q, rand_snap;
    logic [1:0]        sel, reason;
    logic              busy, done;
    logic [GEN_W-1:0]  gen_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gol_run_ctrl #(
        .GEN_W    (GEN_W),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .step        (step),
        .seed_random (seed_random),
        .gen_limit   (gen_limit),
        .grid_state  (dp_q),
        .sel         (sel),
        .busy        (busy),
        .done        (done),
        .reason      (reason),
        .gen_count   (gen_count)
    );

    // Life rule on an 8x8 grid with dead cells beyond the border.
    function automatic logic [63:0] life_next(input logic [63:0] g);
        logic [63:0] n;
        int cnt, rr, cc;
        n = 64'd0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = r + dr;
                        cc = c + dc;
                        if (!(dr == 0 && dc == 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8) begin
                            if (g[rr*8+cc]) cnt++;
                        end
                    end
                end
                n[r*8+c] = (cnt == 3) || (g[r*8+c] && cnt == 2);
            end
        end
        return n;
    endfunction

    // Generation-level prediction of a full run from a seed.
    function automatic void model_run(input logic [63:0] seed, input logic [15:0] limit,
                                      output logic [1:0] er, output int eg,
                                      output logic [63:0] egrid);
        logic [63:0] older, cur, nxt;
        logic [1:0]  r;
        bit found;
        older = 64'd0; cur = seed; found = 1'b0;
        er = 2'd0; eg = 0; egrid = seed;
        for (int g = 1; g <= 500 && !found; g++) begin
            nxt = life_next(cur);
            if (nxt == 64'd0) r = 2'd1;
            else if (nxt == cur) r = 2'd2;
`ifdef GOL_OSC2_DETECT_EN
            else if (g >= 2 && nxt == older) r = 2'd2;
`endif
            else if (limit != 16'd0 && g == int'(limit)) r = 2'd3;
            else r = 2'd0;
            older = cur;
            cur = nxt;
            if (r != 2'd0) begin
                found = 1'b1; er = r; eg = g; egrid = cur;
            end
        end
    endfunction

    // Behavioural datapath: grid register selected by sel, plus LFSR.
    always_ff @(posedge clk) begin
        if (reset) begin
            dp_q <= 64'd0;
        end else begin
            case (sel)
                2'b00: dp_q <= user_grid;
                2'b01: dp_q <= life_next(dp_q);
                2'b10: dp_q <= dp_q;
                default: begin
                    dp_q      <= lfsr_q;
                    rand_snap <= lfsr_q;
                end
            endcase
        end
    end

    // Free-running 64-bit LFSR for random seeding.
    always_ff @(posedge clk) begin
        if (reset) lfsr_q <= 64'hACE1_1234_5678_9ABD;
        else       lfsr_q <= {lfsr_q[62:0], lfsr_q[63] ^ lfsr_q[62] ^ lfsr_q[60] ^ lfsr_q[59]};
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0;
        seed_random = 1'b0; gen_limit = 16'd0; user_grid = 64'd0;
        rand_snap = 64'd0;
        cyc(); cyc();
        reset = 1'b0;
        cyc();
        checks++;
        if (sel !== 2'b00 || busy !== 1'b0 || done !== 1'b0 || reason !== 2'b00 || gen_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: sel=%b busy=%b done=%b reason=%b gen=%0d, want 00 0 0 00 0",
                     sel, busy, done, reason, gen_count);
        end
    endtask

    // Single cell: exact sel/busy timeline and an EXTINCT halt after gen 1.
    task automatic test_extinct();
        logic [1:0] exp_sel [8];
        logic       exp_busy [8];
        exp_sel  = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
        exp_busy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        user_grid = G_SINGLE; seed_random = 1'b0; gen_limit = 16'd0;
        for (int i = 0; i < 8; i++) begin
            if (i == 1) start = 1'b0;
            checks++;
            if (sel !== exp_sel[i] || busy !== exp_busy[i]) begin
                errors++;
                $display("FAIL extinct_seq[%0d]: sel=%b busy=%b, want %b %b", i, sel, busy, exp_sel[i], exp_busy[i]);
            end
            if (i == 0) start = 1'b1;
            cyc();
        end
        checks++;
        if (done !== 1'b1 || reason !== 2'b01 || gen_count !== 16'd1 || busy !== 1'b0 || sel !== 2'b10) begin
            errors++;
            $display("FAIL extinct_halt: done=%b reason=%b gen=%0d busy=%b sel=%b, want 1 01 1 0 10",
                     done, reason, gen_count, busy, sel);
        end
    endtask

    // Start a run and compare the halt against the reference model.
    task automatic run_to_halt(input logic [63:0] seed, input logic rnd, input logic [15:0] limit,
                               input string name, output logic [1:0] er, output int eg);
        logic [63:0] used_seed, egrid;
        int cycles;
        user_grid = seed; seed_random = rnd; gen_limit = limit;
        start = 1'b1; cyc(); start = 1'b0;
        checks++;
        if (sel !== (rnd ? 2'b11 : 2'b00) || done !== 1'b0 || reason !== 2'b00 || gen_count !== 16'd0) begin
            errors++;
            $display("FAIL %s_seed: sel=%b done=%b reason=%b gen=%0d, want %b 0 00 0",
                     name, sel, done, reason, gen_count, rnd ? 2'b11 : 2'b00);
        end
        cyc();
        used_seed = rnd ? rand_snap : seed;
        model_run(used_seed, limit, er, eg, egrid);
        cycles = 2;
        while (done !== 1'b1 && cycles < 2000) begin
            cyc();
            cycles++;
        end
        checks++;
        if (done !== 1'b1 || cycles != eg * PERIOD + 2) begin
            errors++;
            $display("FAIL %s_latency: done=%b after %0d cycles, want 1 after %0d", name, done, cycles, eg * PERIOD + 2);
        end
        checks++;
        if (reason !== er || gen_count !== 16'(eg) || dp_q !== egrid || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_result: reason=%b gen=%0d grid=%h busy=%b, want %b %0d %h 0",
                     name, reason, gen_count, dp_q, busy, er, eg, egrid);
        end
    endtask

    task automatic test_block();
        logic [1:0] er; int eg;
        run_to_halt(G_BLOCK, 1'b0, 16'd0, "block", er, eg);
        checks++;
        if (reason !== 2'b10 || gen_count !== 16'd1 || dp_q !== G_BLOCK) begin
            errors++;
            $display("FAIL block_const: reason=%b gen=%0d grid=%h, want 10 1 %h", reason, gen_count, dp_q, G_BLOCK);
        end
    endtask

    task automatic test_blinker_limit();
        logic [1:0] er; int eg;
        run_to_halt(G_BLINKER, 1'b0, 16'd5, "blinker", er, eg);
        checks++;
`ifdef GOL_OSC2_DETECT_EN
        if (reason !== 2'b10 || gen_count !== 16'd2) begin
            errors++;
            $display("FAIL blinker_const: reason=%b gen=%0d, want 10 2", reason, gen_count);
        end
`else
        if (reason !== 2'b11 || gen_count !== 16'd5) begin
            errors++;
            $display("FAIL blinker_const: reason=%b gen=%0d, want 11 5", reason, gen_count);
        end
`endif
    endtask

    // Pause, 20-cycle hold, 3 single steps, resume, stop on the tick, stop+start.
    task automatic test_pause_step();
        logic [63:0] g;
        int runs;
        user_grid = G_PAUSE; seed_random = 1'b0; gen_limit = 16'd0;
        g = G_PAUSE;
        start = 1'b1; cyc(); start = 1'b0;   // SEED
        cyc();                               // RUN cycle 1
        cyc();                               // RUN cycle 2
        stop = 1'b1; cyc(); stop = 1'b0;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (sel !== 2'b10 || busy !== 1'b0 || done !== 1'b0 || gen_count !== 16'd0) begin
                errors++;
                $display("FAIL pause_hold[%0d]: sel=%b busy=%b done=%b gen=%0d, want 10 0 0 0",
                         i, sel, busy, done, gen_count);
            end
            cyc();
        end
        for (int k = 1; k <= 3; k++) begin
            step = 1'b1; cyc(); step = 1'b0;
            checks++;
            if (sel !== 2'b01 || busy !== 1'b1) begin
                errors++;
                $display("FAIL step_evolve[%0d]: sel=%b busy=%b, want 01 1", k, sel, busy);
            end
            cyc(); cyc();
            g = life_next(g);
            checks++;
            if (sel !== 2'b10 || busy !== 1'b0 || done !== 1'b0 || gen_count !== 16'(k) || dp_q !== g) begin
                errors++;
                $display("FAIL step_paused[%0d]: sel=%b busy=%b done=%b gen=%0d grid=%h, want 10 0 0 %0d %h",
                         k, sel, busy, done, gen_count, dp_q, k, g);
            end
        end
        start = 1'b1; cyc(); start = 1'b0;
        runs = 0;
        while (sel === 2'b10 && busy === 1'b1 && runs < 50) begin
            runs++;
            cyc();
        end
        checks++;
        if (runs != TICK_DIV || sel !== 2'b01) begin
            errors++;
            $display("FAIL resume_wait: %0d RUN cycles then sel=%b, want %0d then 01", runs, sel, TICK_DIV);
        end
        cyc(); cyc();                        // CHECK, then RUN cycle 1
        g = life_next(g);
        checks++;
        if (sel !== 2'b10 || busy !== 1'b1 || gen_count !== 16'd4 || dp_q !== g) begin
            errors++;
            $display("FAIL resume_gen: sel=%b busy=%b gen=%0d grid=%h, want 10 1 4 %h", sel, busy, gen_count, dp_q, g);
        end
        for (int i = 1; i < TICK_DIV; i++) cyc();
        stop = 1'b1; cyc(); stop = 1'b0;     // stop on the last RUN cycle
        checks++;
        if (sel !== 2'b10 || busy !== 1'b0 || gen_count !== 16'd4) begin
            errors++;
            $display("FAIL stop_on_tick: sel=%b busy=%b gen=%0d, want 10 0 4", sel, busy, gen_count);
        end
        cyc();
        checks++;
        if (sel !== 2'b10 || dp_q !== g) begin
            errors++;
            $display("FAIL stop_no_evolve: sel=%b grid=%h, want 10 %h", sel, dp_q, g);
        end
        stop = 1'b1; start = 1'b1; cyc(); stop = 1'b0; start = 1'b0;
        checks++;
        if (sel !== 2'b00 || busy !== 1'b0 || done !== 1'b0 || gen_count !== 16'd4) begin
            errors++;
            $display("FAIL stop_start_idle: sel=%b busy=%b done=%b gen=%0d, want 00 0 0 4", sel, busy, done, gen_count);
        end
    endtask

    task automatic test_random();
        logic [63:0] seed;
        logic [15:0] lim;
        logic [1:0]  er;
        int eg;
        for (int n = 0; n < 8; n++) begin
            seed = {$urandom, $urandom} & {$urandom, $urandom};
            lim  = 16'($urandom_range(1, 6));
            run_to_halt(seed, (n >= 6) ? 1'b1 : 1'b0, lim, "random", er, eg);
        end
    endtask

    // reset during the second EVOLVE abandons the run.
    task automatic test_reset_evolve();
        int n;
        user_grid = G_BLINKER; seed_random = 1'b0; gen_limit = 16'd0;
        start = 1'b1; cyc(); start = 1'b0;
        for (int e = 0; e < 2; e++) begin
            if (e == 1) cyc();
            n = 0;
            while (sel !== 2'b01 && n < 100) begin
                cyc();
                n++;
            end
        end
        checks++;
        if (sel !== 2'b01 || gen_count !== 16'd1) begin
            errors++;
            $display("FAIL reset_evolve_pre: sel=%b gen=%0d, want 01 1", sel, gen_count);
        end
        reset = 1'b1; cyc(); reset = 1'b0;
        checks++;
        if (sel !== 2'b00 || gen_count !== 16'd0 || done !== 1'b0 || busy !== 1'b0 || reason !== 2'b00) begin
            errors++;
            $display("FAIL reset_evolve: sel=%b gen=%0d done=%b busy=%b reason=%b, want 00 0 0 0 00",
                     sel, gen_count, done, busy, reason);
        end
        stop = 1'b1; step = 1'b1; cyc(); stop = 1'b0; step = 1'b0;
        checks++;
        if (sel !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignores: sel=%b busy=%b, want 00 0", sel, busy);
        end
    endtask

    initial begin
        test_reset();
        test_extinct();
        test_block();
        test_blinker_limit();
        test_pause_step();
        test_random();
        test_reset_evolve();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gol_run_ctrl.md
Name: gol_run_ctrl

Overview:
- Run-control FSM for the 8x8 Game-of-Life datapath (`data`: Grid, clk, reset, a, Grid_Evolved).
- Drives the datapath's 2-bit source select `a` to sequence the following operations:
  - seed from the user grid or the LFSR;
  - evolve one generation per pacing tick;
  - hold between ticks;
  - pause, single-step and stop.
- Watches Grid_Evolved to count generations and to detect extinction, still life and the generation limit.

Parameters:
- GEN_W, 16, width of the generation counter and the limit.
- TICK_DIV, 4, number of RUN hold cycles between evolutions (≥1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse; seed and run (IDLE/HALT) or resume (PAUSED).
- stop  in  1  pulse; pause (RUN) or abort to IDLE (PAUSED).
- step  in  1  pulse; evolve one generation while PAUSED.
- seed_random  in  1  sampled with start: 1 = seed from LFSR, 0 = seed from Grid.
- gen_limit  in  GEN_W  halt after this many generations; 0 = unlimited.
- grid_state  in  64  Grid_Evolved fed back from the datapath.
- sel  out  2  drives datapath `a`.
- busy  out  1  high in SEED/RUN/EVOLVE/CHECK.
- done  out  1  level, high in HALT.
- reason  out  2  halt cause.
- gen_count  out  GEN_W  generations evolved since the last seed.

Behaviour:
- Select encoding (sel):
  - LOAD = 2'b00 (Grid → register);
  - EVOLVE = 2'b01 (next generation);
  - HOLD = 2'b10 (register keeps its value);
  - RANDOM = 2'b11 (LFSR → register).
- All outputs are registered.
- State at reset:
  - FSM state IDLE, sel = LOAD;
  - busy = 0, done = 0, reason = NONE (2'b00), gen_count = 0;
  - tick counter = 0, prev_grid = 0.
- IDLE: sel = LOAD. On start → SEED. stop and step are ignored.
- SEED (1 cycle):
  - sel = RANDOM if seed_random was 1 at start, else LOAD.
  - gen_count ← 0, reason ← NONE.
  - → RUN.
- RUN:
  - sel = HOLD; the tick counter increments each cycle.
  - After exactly TICK_DIV cycles → EVOLVE, and the tick counter clears.
  - stop → PAUSED (stop beats the tick in the same cycle).
- EVOLVE (1 cycle):
  - sel = EVOLVE; prev_grid ← grid_state (the pre-evolution grid).
  - gen_count increments, saturating at all-ones.
  - → CHECK.
- CHECK (1 cycle): sel = HOLD; grid_state now holds the new generation. Checks in priority order:
  - grid_state == 0 → HALT, reason = EXTINCT (2'b01);
  - grid_state == prev_grid → HALT, reason = STABLE (2'b10);
  - gen_limit ≠ 0 and gen_count == gen_limit → HALT, reason = LIMIT (2'b11);
  - otherwise → RUN, or → PAUSED if CHECK was entered from a step.
- PAUSED:
  - sel = HOLD, busy = 0.
  - step → EVOLVE, then CHECK, then back to PAUSED.
  - start → RUN with the tick counter cleared.
  - stop → IDLE (no done; gen_count is retained).
  - Same-cycle priority: stop > start > step.
- HALT:
  - sel = HOLD, done = 1; reason and gen_count are held.
  - start → SEED (done drops in SEED).
- Inputs seen in EVOLVE or CHECK are ignored; pulses are not queued.
- reset in any state returns to IDLE on the next edge; an in-flight evolution is abandoned.
- Latency with TICK_DIV = 4:
  - start sampled at edge 0 → SEED in cycle 1 → RUN in cycles 2-5 → EVOLVE in cycle 6 → CHECK in cycle 7.
  - Generation period = TICK_DIV + 2 cycles.

Optional Feature:
- Macro: GOL_OSC2_DETECT_EN.
- Defined:
  - An extra register prev2_grid ← prev_grid is updated in EVOLVE.
  - In CHECK, grid_state == prev2_grid with gen_count ≥ 2 → HALT, reason = STABLE.
  - This check sits at STABLE priority, so period-2 oscillators halt.
- Undefined:
  - The register is absent, and only period-1 stability is detected.

Decomposition:
- Package gol_pkg holds:
  - sel_t enum {SEL_LOAD, SEL_EVOLVE, SEL_HOLD, SEL_RANDOM};
  - state_t enum {IDLE, SEED, RUN, EVOLVE, CHECK, PAUSED, HALT};
  - reason_t enum {NONE, EXTINCT, STABLE, LIMIT};
  - GRID_W = 64.
- One sub-module, gol_tick_div:
  - a TICK_DIV pacing counter with clear and enable inputs and a one-cycle `tick` output.

Test Plan:
Bench instantiates `data` + gol_run_ctrl with sel → a.
- Reset then start, seed_random = 0, Grid = 64'h0000_0000_0008_0000 (single cell) → HALT after gen 1; done = 1, reason = EXTINCT, gen_count = 1; sel sequence 00, 00, 10×4, 01, 10.
- Grid = 64'h0000_0000_1818_0000 (block) → HALT, reason = STABLE, gen_count = 1; grid unchanged.
- Grid = 64'h0000_0000_0038_0000 (blinker), gen_limit = 5:
  - macro undefined → reason = LIMIT, gen_count = 5;
  - macro defined → reason = STABLE, gen_count = 2.
- Blinker, gen_limit = 0:
  - stop at the 2nd RUN cycle → PAUSED, sel = 10 held for 20 cycles;
  - 3 step pulses → gen_count + 3, still PAUSED;
  - start → RUN resumes with a full TICK_DIV wait.
- Same-cycle events:
  - stop coincident with the last RUN cycle → PAUSED, no EVOLVE;
  - stop + start in PAUSED → IDLE.
- reset asserted during EVOLVE → next cycle IDLE, sel = 00, gen_count = 0, done = 0.
